// File: rtl/bcd_stopwatch_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_pkg
//  Purpose  : Shared types, 7-segment constants and the segment decoder
//             used by the BCD stopwatch and its display scan multiplexer.
//  Contents : bcd_t      - one BCD digit (0..9)
//             SEG_*      - active-low common-anode codes, dp bit (bit7) = 1
//             seg_decode - BCD digit + dp request -> active-low segment byte
//  Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low segment codes, bit7 = dp, bits6:0 = g..a.
  localparam logic [7:0] SEG_D0    = 8'hC0;
  localparam logic [7:0] SEG_D1    = 8'hF9;
  localparam logic [7:0] SEG_D2    = 8'hA4;
  localparam logic [7:0] SEG_D3    = 8'hB0;
  localparam logic [7:0] SEG_D4    = 8'h99;
  localparam logic [7:0] SEG_D5    = 8'h92;
  localparam logic [7:0] SEG_D6    = 8'h82;
  localparam logic [7:0] SEG_D7    = 8'hF8;
  localparam logic [7:0] SEG_D8    = 8'h80;
  localparam logic [7:0] SEG_D9    = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Non-decimal codes fall back to blank so a corrupted digit never lights
  // a misleading pattern.
  function automatic logic [7:0] seg_decode(input bcd_t bcd, input logic dp_on);
    logic [7:0] s;
    case (bcd)
      4'd0:    s = SEG_D0;
      4'd1:    s = SEG_D1;
      4'd2:    s = SEG_D2;
      4'd3:    s = SEG_D3;
      4'd4:    s = SEG_D4;
      4'd5:    s = SEG_D5;
      4'd6:    s = SEG_D6;
      4'd7:    s = SEG_D7;
      4'd8:    s = SEG_D8;
      4'd9:    s = SEG_D9;
      default: s = SEG_BLANK;
    endcase
    if (dp_on) begin
      s[7] = 1'b0;
    end
    return s;
  endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_stopwatch_scan_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Purpose  : Time-multiplexed common-anode 7-segment driver. Steps a digit
//             index every SCAN_DIV clocks and registers the matching segment
//             pattern and one-hot common together.
//  Ports    : clk      - system clock
//             nrst     - asynchronous active-low reset
//             digits_i - packed BCD digits, digit i at [4*i+3:4*i]
//             seg_o    - active-low segments, bit7 = dp, bits6:0 = g..a
//             com_o    - active-low one-hot digit select, com_o[i] = digit i
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 5,
  parameter int SCAN_DIV = 25000,
  parameter int DP_POS   = 2,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [N_DIGITS*4-1:0] digits_i,
  output logic [7:0]            seg_o,
  output logic [N_DIGITS-1:0]   com_o
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);

  logic [SW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] com_q, com_d;
  logic [N_DIGITS-1:0] blank;
  logic                scan_tc;
  bcd_t                cur;
  logic                cur_dp;
  logic                cur_blank;

  // Leading-zero mask: walk from the most significant digit down, blanking
  // while every digit seen so far is zero. Digits at or below DP_POS always
  // show, so "0.00" style readouts keep their integer zero.
  always_comb begin
    logic all_zero;
    blank    = '0;
    all_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (digits_i[i*4 +: 4] == 4'd0);
      if (BLANK_LZ && (i > DP_POS) && all_zero) begin
        blank[i] = 1'b1;
      end
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur       = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur       = digits_i[i*4 +: 4];
        cur_dp    = (i == DP_POS);
        cur_blank = blank[i];
      end
    end
  end

  // Divider, index advance and the registered seg/com pair. seg and com are
  // both derived from idx_q, so they always switch on the same edge.
  always_comb begin
    scan_tc = (div_q == SW'(SCAN_DIV - 1));
    div_d   = scan_tc ? '0 : div_q + SW'(1);
    idx_d   = idx_q;
    if (scan_tc) begin
      idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    seg_d = cur_blank ? SEG_BLANK : seg_decode(cur, cur_dp);
    com_d = ~(N_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      com_q <= '1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      com_q <= com_d;
    end
  end

  assign seg_o = seg_q;
  assign com_o = com_q;

endmodule : seg_scan_mux
`default_nettype wire

// File: rtl/bcd_stopwatch_scan.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_stopwatch_scan
//  Purpose  : N-digit BCD stopwatch with run/pause, synchronous clear,
//             lap-hold and overflow flag, driving a multiplexed common-anode
//             7-segment display.
//  Ports    : clk    - system clock
//             nrst   - asynchronous active-low reset
//             run_i  - level, 1 = count, 0 = pause
//             clr_i  - synchronous clear, active-high
//             lap_i  - asynchronous; each rising edge toggles display hold
//             seg_o  - active-low segments, bit7 = dp, bits6:0 = g..a
//             com_o  - active-low one-hot digit select
//             held_o - display hold active
//             ovf_o  - sticky overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_scan
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 5,
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 25000,
  parameter int DP_POS   = 2,
  parameter bit WRAP     = 1'b1,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                run_i,
  input  logic                clr_i,
  input  logic                lap_i,
  output logic [7:0]          seg_o,
  output logic [N_DIGITS-1:0] com_o,
  output logic                held_o,
  output logic                ovf_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = N_DIGITS * 4;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] latch_q, latch_d;
  logic          ovf_q, ovf_d;
  logic          held_q, held_d;
  // lap_q[0], lap_q[1]: synchroniser stages; lap_q[2]: previous synced level
  logic [2:0]    lap_q, lap_d;
  logic          lap_rise;

  // Prescaler only advances while running, so a pause keeps the partial tick.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clr_i) begin
      presc_d = '0;
    end else if (run_i) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // BCD counter with full same-cycle carry ripple. The all-9s case is handled
  // apart from the ripple so wrap and saturate share one detection point.
  always_comb begin
    logic all9;
    logic carry;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    all9  = 1'b1;
    carry = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      all9 = all9 && (cnt_q[i*4 +: 4] == 4'd9);
    end
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (tick) begin
      if (all9) begin
        ovf_d = 1'b1;
        if (WRAP) begin
          cnt_d = '0;
        end
      end else begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (carry) begin
            if (cnt_q[i*4 +: 4] == 4'd9) begin
              cnt_d[i*4 +: 4] = 4'd0;
            end else begin
              cnt_d[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
              carry           = 1'b0;
            end
          end
        end
      end
    end
  end

  // Lap synchroniser and hold toggle. On clear every stage is forced high:
  // if lap is already high nothing changes, and if it is low the falling
  // level just drains through, so no spurious rising edge can appear.
  always_comb begin
    lap_d    = {lap_q[1], lap_q[0], lap_i};
    held_d   = held_q;
    lap_rise = lap_q[1] & ~lap_q[2];
    if (clr_i) begin
      lap_d  = 3'b111;
      held_d = 1'b0;
    end else if (lap_rise) begin
      held_d = ~held_q;
    end
  end

  // Display latch follows the counter one cycle behind unless held.
  always_comb begin
    latch_d = held_q ? latch_q : cnt_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      latch_q <= '0;
      ovf_q   <= 1'b0;
      held_q  <= 1'b0;
      lap_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      ovf_q   <= ovf_d;
      held_q  <= held_d;
      lap_q   <= lap_d;
    end
  end

  seg_scan_mux #(
    .N_DIGITS (N_DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .DP_POS   (DP_POS),
    .BLANK_LZ (BLANK_LZ)
  ) u_scan (
    .clk      (clk),
    .nrst     (nrst),
    .digits_i (latch_q),
    .seg_o    (seg_o),
    .com_o    (com_o)
  );

  assign held_o = held_q;
  assign ovf_o  = ovf_q;

endmodule : bcd_stopwatch_scan
`default_nettype wire
